time_counter: RTL
=================

TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter HOUR_MOD, default 24, hour wrap modulus (legal values 12 or 24; hour range 0..HOUR_MOD-1).
REQ-002 clk_in  input  1  system clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 sec_clk  input  1  divided 1 Hz square wave from the clock divider, synchronous to clk_in, no synchronizer required.
REQ-005 mode_key  input  1  debounced single-cycle pulse, advances mode.
REQ-006 inc_key  input  1  debounced single-cycle pulse, increments selected field in set modes.
REQ-007 hour_bcd  output  8  hours, two BCD digits {tens,units}.
REQ-008 min_bcd  output  8  minutes, two BCD digits.
REQ-009 sec_bcd  output  8  seconds, two BCD digits.
REQ-010 mode  output  2  current mode: 0 RUN, 1 SET_H, 2 SET_M; 3 never produced.
REQ-011 sec_pulse  output  1  registered one-cycle pulse, one clk_in after each accepted sec_clk rising edge.
REQ-012 day_carry  output  1  one-cycle pulse on the cycle the time wraps from (HOUR_MOD-1):59:59 to 00:00:00.

Function
REQ-013 Block SHALL keep sec_clk_q = sec_clk delayed one clk_in; tick = sec_clk & ~sec_clk_q; falling edges ignored.
REQ-014 In RUN, on an edge where tick=1 the time SHALL advance by one second, visible on outputs immediately after that edge (latency 1 clk_in from first sampled-high sec_clk).
REQ-015 Seconds 59->00 SHALL increment minutes in the same edge; minutes 59->00 with seconds 59 SHALL increment hours in the same edge; hours HOUR_MOD-1 -> 00 on full rollover asserts day_carry for exactly that following cycle.
REQ-016 Every BCD digit SHALL stay in 0..9; tens digits SHALL stay 0..5 (sec/min) and 0..2 (hour); no binary intermediate visible on outputs.
REQ-017 FSM transitions on mode_key: RUN->SET_H->SET_M->RUN; no other transitions.
REQ-018 In SET_H and SET_M, ticks SHALL be ignored (time frozen, sec_pulse still generated).
REQ-019 inc_key in SET_H SHALL increment hours modulo HOUR_MOD; in SET_M minutes modulo 60; no carry into other fields; day_carry never asserted by inc_key.
REQ-020 inc_key in RUN SHALL be ignored.
REQ-021 Transition SET_M->RUN SHALL clear seconds to 00 on the same edge.
REQ-022 mode_key and inc_key in the same cycle: mode change taken, inc_key ignored.
REQ-023 mode_key and tick in the same RUN cycle: tick applied (including carries) and mode becomes SET_H on the same edge.
REQ-024 sec_pulse SHALL assert for every detected tick in any mode, exactly one cycle later.

Reset
REQ-025 rst_n=0 sampled on a clk_in edge SHALL set time to 00:00:00, mode RUN, sec_pulse 0, day_carry 0.
REQ-026 sec_clk_q SHALL reset to 1 so sec_clk already high at reset release does not produce a tick.
REQ-027 Reset mid-operation (any mode, any time value, coincident with tick or keys) SHALL take priority over all other events.

Structure
REQ-028 Shared package time_pkg SHALL hold the mode encoding constants and the 60 minute/second modulus.
REQ-029 One sub-module bcd_mod_counter (two-digit BCD, modulus parameter, inc in, wrap-out pulse) SHALL be instantiated three times (sec, min, hour).
REQ-030 All outputs SHALL be driven directly from registers.

Verification
REQ-031 Reset, then sec_clk 0->1 -> sec_bcd 0x01 one cycle after first sampled high, sec_pulse one cycle later still, no second tick while sec_clk stays high.
REQ-032 Preload 23:59:59 (HOUR_MOD=24) via set modes plus ticks, one tick -> 00:00:00 and day_carry one cycle; HOUR_MOD=12 from 11:59:59 -> 00:00:00.
REQ-033 mode_key x1, inc_key x25 -> hour_bcd 0x01; mode_key, inc_key x61 -> min_bcd 0x01; ticks during set -> sec_bcd unchanged.
REQ-034 Time 00:00:37 in SET_M, mode_key -> mode 0, sec_bcd 0x00.
REQ-035 mode_key+inc_key same cycle in SET_H -> mode 2, hour unchanged; mode_key+tick same cycle in RUN at 00:00:59 -> 00:01:00, mode 1.
REQ-036 rst_n low while sec_clk high at 12:34:56 -> 00:00:00, no tick on release until sec_clk falls and rises again.

Source files
------------

// File: rtl/time_pkg.sv
// Shared definitions for the time-of-day counter: mode encoding,
// seconds/minutes modulus and a binary-to-BCD helper for constants.
package time_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_H = 2'd1,
        MODE_SET_M = 2'd2
    } mode_e;

    localparam int SEC_MIN_MOD = 60;

    function automatic logic [7:0] to_bcd(input int unsigned n);
        logic [3:0] tens;
        logic [3:0] units;
        tens   = 4'((n / 10) % 10);
        units  = 4'(n % 10);
        to_bcd = {tens, units};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter with programmable modulus, synchronous clear
// and a combinational wrap flag so carries ripple within one edge.
import time_pkg::*;

module bcd_mod_counter #(
    parameter int MOD = 60
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] value,
    output logic       wrap
);

    localparam logic [7:0] LAST = to_bcd(MOD - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign wrap  = inc & (cnt_q == LAST);
    assign value = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'h00;
        end else if (inc) begin
            if (cnt_q == LAST) begin
                cnt_d = 8'h00;
            end else if (cnt_q[3:0] == 4'd9) begin
                cnt_d = {cnt_q[7:4] + 4'd1, 4'd0};
            end else begin
                cnt_d = {cnt_q[7:4], cnt_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_counter.sv
// Clock-of-day core: 1 Hz edge detect, RUN/SET_H/SET_M mode FSM and
// three chained BCD counters for seconds, minutes and hours.
import time_pkg::*;

module time_counter #(
    parameter int HOUR_MOD = 24
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       sec_clk,
    input  logic       mode_key,
    input  logic       inc_key,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       sec_pulse,
    output logic       day_carry
);

    mode_e state_q;
    mode_e state_d;

    logic sec_clk_q;
    logic tick;
    logic tick_q;
    logic sec_pulse_q;
    logic day_carry_q;

    logic run;
    logic set_h;
    logic set_m;
    logic key_inc;

    logic sec_inc;
    logic sec_clr;
    logic min_inc;
    logic hour_inc;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;

    assign tick    = sec_clk & ~sec_clk_q;
    assign run     = (state_q == MODE_RUN);
    assign set_h   = (state_q == MODE_SET_H);
    assign set_m   = (state_q == MODE_SET_M);
    // A mode change always wins over a coincident increment key.
    assign key_inc = inc_key & ~mode_key;

    assign sec_inc  = run & tick;
    assign sec_clr  = set_m & mode_key;
    assign min_inc  = (run & sec_wrap) | (set_m & key_inc);
    assign hour_inc = (run & min_wrap) | (set_h & key_inc);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MODE_RUN:   if (mode_key) state_d = MODE_SET_H;
            MODE_SET_H: if (mode_key) state_d = MODE_SET_M;
            MODE_SET_M: if (mode_key) state_d = MODE_RUN;
            default:    state_d = MODE_RUN;
        endcase
    end

    // Edge detector starts high so a level already high at reset is ignored.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= MODE_RUN;
            sec_clk_q   <= 1'b1;
            tick_q      <= 1'b0;
            sec_pulse_q <= 1'b0;
            day_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_clk_q   <= sec_clk;
            tick_q      <= tick;
            sec_pulse_q <= tick_q;
            day_carry_q <= run & hour_wrap;
        end
    end

    bcd_mod_counter #(.MOD(SEC_MIN_MOD)) u_sec (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr    (sec_clr),
        .inc    (sec_inc),
        .value  (sec_bcd),
        .wrap   (sec_wrap)
    );

    bcd_mod_counter #(.MOD(SEC_MIN_MOD)) u_min (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .inc    (min_inc),
        .value  (min_bcd),
        .wrap   (min_wrap)
    );

    bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .inc    (hour_inc),
        .value  (hour_bcd),
        .wrap   (hour_wrap)
    );

    assign mode      = state_q;
    assign sec_pulse = sec_pulse_q;
    assign day_carry = day_carry_q;

endmodule
